// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshake data memory.
//   state_e  : controller states (CLEAR only reachable with DMEM_INIT_ZERO_EN)
//   is_pow2  : true for non-zero powers of two
//   size_ok  : transfer size is a power of two no larger than the bus width in bytes
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  function automatic logic is_pow2(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic logic size_ok(input logic [31:0] size, input logic [31:0] data_bytes);
    return is_pow2(size) && (size <= data_bytes);
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check for one memory request.
//   i_addr  : request byte address
//   i_size  : transfer size in bytes
//   o_legal : size is 1,2,4..DATA_BYTES, address naturally aligned, and the whole
//             transfer lies inside the array
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SZ_W       = 4
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [SZ_W-1:0]   i_size,
  output logic              o_legal
);

  logic              w_size_ok;
  logic              w_aligned;
  logic              w_in_bounds;
  logic [ADDR_W-1:0] w_mask;
  logic [ADDR_W:0]   w_end;

  assign w_size_ok = size_ok(32'(i_size), 32'(DATA_BYTES));
  // Mask is only meaningful once the size is known to be a power of two.
  assign w_mask    = ADDR_W'(i_size) - ADDR_W'(1);
  assign w_aligned = ((i_addr & w_mask) == '0);
  // One extra bit so that a transfer near the top of the address space cannot wrap.
  assign w_end       = {1'b0, i_addr} + (ADDR_W + 1)'(i_size);
  assign w_in_bounds = (w_end <= (ADDR_W + 1)'(MEM_BYTES));

  assign o_legal = w_size_ok && w_aligned && w_in_bounds;

endmodule

// File: rtl/dmem_handshake.sv
// Byte-addressed little-endian data memory behind a valid/ready request/response port.
// One request outstanding; the response is registered and appears one cycle after accept.
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_req_valid / o_req_ready : request handshake (ready only in IDLE)
//   i_req_write               : 1 = write, 0 = read
//   i_req_addr                : byte address
//   i_req_xfer_size           : transfer size in bytes (1,2,4..DATA_BYTES)
//   i_req_wdata               : write data, byte i on [8i+7:8i]
//   o_resp_valid/i_resp_ready : response handshake
//   o_resp_rdata              : read data, zero-extended above the transfer size
//   o_resp_err                : request was rejected (bad size, misaligned or out of bounds)
// Optional feature: define DMEM_INIT_ZERO_EN to zero the array after every reset release
// (CLEAR state, DATA_BYTES bytes per cycle, request port held not-ready meanwhile).
module dmem_handshake
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 32,
  localparam int unsigned DATA_BYTES = DATA_W / 8,
  localparam int unsigned SZ_W       = $clog2(DATA_BYTES) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [SZ_W-1:0]   i_req_xfer_size,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err
);

  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);

  state_e            r_state;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic [7:0]        r_mem [MEM_BYTES];

  logic              w_legal;
  logic              w_wr_en;
  logic [MEM_AW-1:0] w_base;
  logic [DATA_W-1:0] w_rdata;

`ifdef DMEM_INIT_ZERO_EN
  localparam logic [MEM_AW-1:0] CLR_LAST = MEM_AW'(MEM_BYTES - DATA_BYTES);
  logic [MEM_AW-1:0] r_clr_addr;
`endif

  dmem_access_check #(
    .MEM_BYTES (MEM_BYTES),
    .DATA_BYTES(DATA_BYTES),
    .ADDR_W    (ADDR_W),
    .SZ_W      (SZ_W)
  ) u_access_check (
    .i_addr (i_req_addr),
    .i_size (i_req_xfer_size),
    .o_legal(w_legal)
  );

  // Only the low address bits index the array; upper bits are covered by the bounds check.
  assign w_base  = i_req_addr[MEM_AW-1:0];
  assign w_wr_en = i_reset_n && (r_state == IDLE) && i_req_valid && i_req_write && w_legal;

  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (SZ_W'(i) < i_req_xfer_size) begin
        w_rdata[8*i+:8] = r_mem[w_base + MEM_AW'(i)];
      end
    end
  end

  // Array has no reset so that contents survive reset_n.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        if (SZ_W'(i) < i_req_xfer_size) begin
          r_mem[w_base + MEM_AW'(i)] <= i_req_wdata[8*i+:8];
        end
      end
    end
`ifdef DMEM_INIT_ZERO_EN
    if (i_reset_n && (r_state == CLEAR)) begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        r_mem[r_clr_addr + MEM_AW'(i)] <= 8'h00;
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
`ifdef DMEM_INIT_ZERO_EN
      r_state    <= CLEAR;
      r_clr_addr <= '0;
`else
      r_state    <= IDLE;
`endif
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= !w_legal;
            r_resp_rdata <= (w_legal && !i_req_write) ? w_rdata : '0;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        CLEAR: begin
`ifdef DMEM_INIT_ZERO_EN
          if (r_clr_addr == CLR_LAST) begin
            r_state <= IDLE;
          end else begin
            r_clr_addr <= r_clr_addr + MEM_AW'(DATA_BYTES);
          end
`else
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_handshake.sv
// Directed self-checking bench for dmem_handshake (default parameters: 1 KiB, 64-bit bus).
module tb_dmem_handshake;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned SZ_W      = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [SZ_W-1:0]   req_xfer_size;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dmem_handshake #(
    .MEM_BYTES(MEM_BYTES),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_addr     (req_addr),
    .i_req_xfer_size(req_xfer_size),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for the request port to open.
  task automatic wait_ready();
    int k = 0;
    while (req_ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) check("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  // One full transaction with resp_ready held high; returns at a negedge in IDLE.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] sz,
                      input logic [63:0] wd, output logic [63:0] rd, output logic er);
    wait_ready();
    req_valid     = 1'b1;
    req_write     = wr;
    req_addr      = addr;
    req_xfer_size = sz;
    req_wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("resp_valid_after_accept", 64'(resp_valid), 64'd1);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [63:0] rd;
  logic        er;

  initial begin
    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = '0;
    req_xfer_size = '0;
    req_wdata     = '0;
    resp_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    reset_n = 1'b1;

    // 1: reset release
`ifdef DMEM_INIT_ZERO_EN
    begin
      int busy = 0;
      while (req_ready !== 1'b1 && busy < 400) begin
        busy++;
        @(negedge clk);
      end
      check("clear_cycles", 64'(busy), 64'd128);
    end
`else
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);
    check("resp_valid_after_reset", 64'(resp_valid), 64'd0);
`endif

    // 2: basic write / partial and full reads
    xfer(1'b1, 32'h10, 4'd8, 64'h0123_4567_89AB_CDEF, rd, er);
    check("wr8_err", 64'(er), 64'd0);
    check("wr8_rdata", rd, 64'd0);
    xfer(1'b0, 32'h10, 4'd1, 64'd0, rd, er);
    check("rd1_0x10", rd, 64'hEF);
    check("rd1_err", 64'(er), 64'd0);
    xfer(1'b0, 32'h16, 4'd2, 64'd0, rd, er);
    check("rd2_0x16", rd, 64'h0123);
    xfer(1'b0, 32'h14, 4'd4, 64'd0, rd, er);
    check("rd4_0x14", rd, 64'h0123_4567);
    xfer(1'b0, 32'h10, 4'd8, 64'd0, rd, er);
    check("rd8_0x10", rd, 64'h0123_4567_89AB_CDEF);
    check("rd8_err", 64'(er), 64'd0);

    // 3/4: errors and boundaries
    xfer(1'b0, 32'h12, 4'd4, 64'd0, rd, er);
    check("misalign_err", 64'(er), 64'd1);
    check("misalign_rdata", rd, 64'd0);
    xfer(1'b1, 32'h3F8, 4'd8, 64'h1122_3344_5566_7788, rd, er);
    check("last_dword_err", 64'(er), 64'd0);
    xfer(1'b1, 32'h3FC, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, rd, er);
    check("bad_wr_err", 64'(er), 64'd1);
    xfer(1'b0, 32'h3FC, 4'd4, 64'd0, rd, er);
    check("bad_wr_no_effect", rd, 64'h1122_3344);
    xfer(1'b0, 32'h400, 4'd8, 64'd0, rd, er);
    check("oob_err", 64'(er), 64'd1);
    xfer(1'b0, 32'hFFFF_FFF8, 4'd8, 64'd0, rd, er);
    check("wrap_err", 64'(er), 64'd1);
    check("wrap_rdata", rd, 64'd0);
    xfer(1'b0, 32'h0, 4'd3, 64'd0, rd, er);
    check("size3_err", 64'(er), 64'd1);
    xfer(1'b0, 32'h0, 4'd0, 64'd0, rd, er);
    check("size0_err", 64'(er), 64'd1);
    xfer(1'b0, 32'h0, 4'd12, 64'd0, rd, er);
    check("size12_err", 64'(er), 64'd1);
    xfer(1'b0, 32'h3FF, 4'd1, 64'd0, rd, er);
    check("last_byte_err", 64'(er), 64'd0);
    check("last_byte_rdata", rd, 64'h11);

    // 5: response back-pressure
    wait_ready();
    resp_ready    = 1'b0;
    req_valid     = 1'b1;
    req_write     = 1'b0;
    req_addr      = 32'h10;
    req_xfer_size = 4'd8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid     = 1'b1;
      req_write     = 1'b1;
      req_addr      = 32'h10;
      req_xfer_size = 4'd8;
      req_wdata     = 64'hDEAD_BEEF_DEAD_BEEF;
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
      check("hold_err", 64'(resp_err), 64'd0);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 64'(resp_valid), 64'd0);
    check("release_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    xfer(1'b0, 32'h10, 4'd8, 64'd0, rd, er);
    check("ignored_write", rd, 64'h0123_4567_89AB_CDEF);

    // 6: reset during RESP after a write
    wait_ready();
    req_valid     = 1'b1;
    req_write     = 1'b1;
    req_addr      = 32'h20;
    req_xfer_size = 4'd8;
    req_wdata     = 64'hCAFE_F00D_1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("pre_reset_valid", 64'(resp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_drops_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h20, 4'd8, 64'd0, rd, er);
`ifdef DMEM_INIT_ZERO_EN
    check("post_reset_read", rd, 64'd0);
`else
    check("post_reset_read", rd, 64'hCAFE_F00D_1234_5678);
`endif
    check("post_reset_err", 64'(er), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
